// File: rtl/usb_pkg.sv
// Shared definitions for the USB CDC transmit path.
// Holds the packetizer FSM encoding and default packet/timeout sizing.
// No logic; imported by usb_tx_packetizer.
package usb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // FIFO empty, nothing pending
    ST_COLLECT = 2'd1,  // bytes buffered, waiting for a send trigger
    ST_SEND    = 2'd2   // streaming one packet to the endpoint
  } state_t;

  // One full-speed bulk packet, and 1 ms of idle at 48 MHz.
  localparam int MAX_PKT_DEF = 64;
  localparam int TIMEOUT_DEF = 48000;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO with occupancy output.
// Latency: a pushed byte is visible on rdata the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty.
// Ports: clk_i/rst_n_i clock and async active-low reset; push/wdata write side;
//        pop/rdata read side (rdata is the current head); level occupancy.
module byte_fifo #(
  parameter int DEPTH = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               rdata,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (level != LW'(DEPTH));
  assign do_pop  = pop && (level != '0);
  assign rdata   = mem[rptr];

  // Storage is not reset; stale contents are never visible because level gates reads.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/usb_tx_packetizer.sv
// Groups JTAG-bridge response bytes into USB CDC IN packets of at most MAX_PKT bytes.
// Latency: a packet starts the cycle after a trigger (full packet, idle timeout or flush).
// Backpressure: in_ready_o falls only when the FIFO is full; out_ready_i low freezes the output byte.
// Ports: in_* byte input (valid/ready), flush_i send-now pulse, out_* byte stream with
//        out_last_o marking the packet end, level_o FIFO occupancy.
module usb_tx_packetizer
  import usb_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int MAX_PKT = MAX_PKT_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [7:0]               in_data_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic                     flush_i,
  output logic [7:0]               out_data_o,
  output logic                     out_valid_o,
  output logic                     out_last_o,
  input  logic                     out_ready_i,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int LW  = $clog2(DEPTH) + 1;
  localparam int PLW = $clog2(MAX_PKT + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [PLW-1:0]   pkt_len_q, pkt_len_d;
  logic [PLW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [7:0]       head;
  logic             push;
  logic             pop;
  logic             last_beat;
  logic             pkt_full;

  assign in_ready_o  = (level_o < LW'(DEPTH));
  assign push        = in_valid_i && in_ready_o;
  assign out_valid_o = (state_q == ST_SEND);
  assign pop         = out_valid_o && out_ready_i;
  assign last_beat   = (cnt_q == pkt_len_q - PLW'(1));
  assign out_last_o  = out_valid_o && last_beat;
  // Head only changes on a pop, so data holds while stalled; zero outside SEND.
  assign out_data_o  = out_valid_o ? head : 8'h00;
  assign pkt_full    = (level_o >= LW'(MAX_PKT));

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push    (push),
    .wdata   (in_data_i),
    .pop     (pop),
    .rdata   (head),
    .level   (level_o)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      pkt_len_q <= '0;
      cnt_q     <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      pkt_len_q <= pkt_len_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pkt_len_d = pkt_len_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;

    case (state_q)
      ST_IDLE: begin
        if (push) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        // Level is at least 1 here, so the latched length is never zero.
        // level_o is the pre-write value, so a same-cycle push is not counted.
        if (pkt_full || (timer_q == TW'(TIMEOUT - 1)) || flush_i) begin
          state_d   = ST_SEND;
          pkt_len_d = pkt_full ? PLW'(MAX_PKT) : PLW'(level_o);
          cnt_d     = '0;
        end
      end
      ST_SEND: begin
        if (pop) begin
          if (last_beat) begin
            cnt_d   = '0;
            // Occupancy after this edge is level-1 plus any same-cycle push.
            state_d = ((level_o > LW'(1)) || push) ? ST_COLLECT : ST_IDLE;
          end else begin
            cnt_d = cnt_q + PLW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q != ST_COLLECT) || push) begin
      timer_d = '0;
    end else if (timer_q != TW'(TIMEOUT - 1)) begin
      timer_d = timer_q + TW'(1);
    end
  end

endmodule

// File: tb/tb_usb_tx_packetizer.sv
// Self-checking bench for usb_tx_packetizer: scoreboard of expected output bytes,
// a vector table of push/flush/wait cases, and hand sequences for the multi-cycle corners.
module tb_usb_tx_packetizer;

  localparam int DEPTH   = 64;
  localparam int MAX_PKT = 64;
  localparam int TIMEOUT = 20;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          flush = 1'b0;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_ready = 1'b1;
  logic [LW-1:0] level;

  always #5 clk = ~clk;

  usb_tx_packetizer #(.DEPTH(DEPTH), .MAX_PKT(MAX_PKT), .TIMEOUT(TIMEOUT)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .flush_i     (flush),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_last_o  (out_last),
    .out_ready_i (out_ready),
    .level_o     (level)
  );

  typedef struct {
    logic [7:0] dat;
    bit         chk_last;
    bit         last;
  } exp_t;

  typedef struct {
    int n;
    bit use_flush;
    int wait_cyc;
    bit exp_vld;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_pass = 0;
  int   rx_cnt = 0;
  int   base;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, got, want);
  endtask

  // Output monitor: scoreboard compare on every transfer, stability while stalled.
  logic       stall_q = 1'b0;
  logic [7:0] stall_dat = 8'h00;
  logic       stall_last = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q && out_valid) begin
        check("stall_data", 32'(out_data), 32'(stall_dat));
        check("stall_last", 32'(out_last), 32'(stall_last));
      end
      if (out_valid && out_ready) begin
        rx_cnt++;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL extra_byte: got %0h, want no byte", out_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(mon_e.dat));
          if (mon_e.chk_last) check("out_last", 32'(out_last), 32'(mon_e.last));
        end
      end
      stall_q    = out_valid && !out_ready;
      stall_dat  = out_data;
      stall_last = out_last;
    end
  end

  task automatic push_byte(input logic [7:0] b, input bit chk, input bit lst);
    bit   done = 1'b0;
    exp_t e;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.dat = b; e.chk_last = chk; e.last = lst;
        exp_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_chk++;
      $display("FAIL push_timeout: byte %0h not accepted, want accepted", b);
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic drain();
    int i = 0;
    while ((exp_q.size() != 0 || out_valid) && i < 1000) begin
      @(posedge clk); #1;
      i++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    check("drain_level", 32'(level), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  vec_t vecs[6];

  initial begin
    vecs[0] = '{5, 1'b1, 1, 1'b1};                    // flush right after last push
    vecs[1] = '{1, 1'b1, 1, 1'b1};                    // single-byte packet via flush
    vecs[2] = '{2, 1'b0, 1, 1'b0};                    // no trigger yet
    vecs[3] = '{7, 1'b0, TIMEOUT - 1, 1'b0};          // one cycle short of timeout
    vecs[4] = '{7, 1'b0, TIMEOUT, 1'b1};              // timeout fires
    vecs[5] = '{MAX_PKT, 1'b0, 1, 1'b1};              // full packet triggers at once

    // Reset state while held in reset.
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Three bytes, then wait out the idle timeout.
    push_byte(8'h31, 1'b1, 1'b0);
    push_byte(8'h30, 1'b1, 1'b0);
    push_byte(8'h31, 1'b1, 1'b1);
    repeat (TIMEOUT - 1) begin @(posedge clk); #1; end
    check("to_early_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("to_valid", 32'(out_valid), 32'd1);
    check("to_first_data", 32'(out_data), 32'h31);
    check("to_first_last", 32'(out_last), 32'd0);
    drain();

    // Flush with an empty FIFO is ignored.
    pulse_flush();
    check("idle_flush_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("idle_flush_valid2", 32'(out_valid), 32'd0);

    // Vector table.
    for (int vi = 0; vi < 6; vi++) begin
      for (int j = 0; j < vecs[vi].n; j++)
        push_byte(8'($urandom), 1'b1, j == vecs[vi].n - 1);
      if (vecs[vi].use_flush) flush = 1'b1;
      for (int k = 0; k < vecs[vi].wait_cyc; k++) begin
        @(posedge clk); #1;
        flush = 1'b0;
      end
      check($sformatf("vec%0d_valid", vi), 32'(out_valid), 32'(vecs[vi].exp_vld));
      drain();
    end

    // 130 back-to-back bytes: packets of 64, 64 and 2.
    for (int i = 0; i < 130; i++)
      push_byte(8'(i), 1'b1, (i == 63) || (i == 127) || (i == 129));
    drain();

    // Overfill with the endpoint stalled.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      push_byte(8'(i + 50), 1'b1, i == 63);
    check("full_level", 32'(level), 32'(DEPTH));
    check("full_in_ready", 32'(in_ready), 32'd0);
    fork
      begin
        repeat (10) @(posedge clk);
        #1;
        check("stall_offer_level", 32'(level), 32'(DEPTH));
        check("stall_offer_rdy", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
      end
      begin
        for (int i = DEPTH; i < DEPTH + 4; i++)
          push_byte(8'(i + 50), 1'b1, i == DEPTH + 3);
      end
    join
    drain();

    // Random endpoint backpressure with pushes continuing during SEND.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          push_byte(8'($urandom), 1'b0, 1'b0);
          if (i % 8 == 7) pulse_flush();
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
      end
      begin
        for (int c = 0; c < 300; c++) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset after 10 of 40 bytes of a packet have been sent.
    out_ready = 1'b0;
    for (int i = 0; i < 40; i++)
      push_byte(8'(i + 100), 1'b0, 1'b0);
    pulse_flush();
    base = rx_cnt;
    out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (rx_cnt == base + 10) break;
      @(posedge clk); #1;
    end
    check("mid_sent", 32'(rx_cnt - base), 32'd10);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    push_byte(8'hA5, 1'b1, 1'b1);
    pulse_flush();
    check("fresh_valid", 32'(out_valid), 32'd1);
    check("fresh_data", 32'(out_data), 32'hA5);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
